// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage:
//   NOP_INSTR      canonical RV32I NOP (addi x0, x0, 0) used for bubbles
//   OPCODE_JAL     major opcode of JAL, used by the optional JAL predecode
//   fetch_state_t  request tracking states of the fetch FSM
//   j_imm()        extracts the sign-extended J-type immediate (bit0 = 0)
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [6:0]  OPCODE_JAL = 7'b1101111;

    // IDLE: request out; WAIT: response pending; HOLD: response parked in
    // the hold buffer; DROP: response pending but must be thrown away.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    // J-type immediate: imm[20|10:1|11|19:12] packed into instr[31:12].
    function automatic logic [31:0] j_imm(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch
// Instruction fetch stage with a single outstanding instruction-memory
// request, a one-entry hold buffer for responses that arrive while decode is
// stalled, and redirect (branch/jump) handling that flushes in-flight work.
//
// Parameters:
//   RESET_PC            first fetch address after reset
// Ports:
//   clk                 clock, rising edge
//   reset               asynchronous, active-high reset
//   i_pipe_stall        decode cannot accept; pipe outputs hold
//   i_Redirect          redirect request, highest priority
//   i_RedirectPC        redirect target (low two bits ignored)
//   o_ImemReq           imem request valid
//   o_ImemAddr          word-aligned fetch address (the PC)
//   i_ImemGnt           imem accepted the request this cycle
//   i_ImemRvalid        imem response valid
//   i_ImemRdata         imem response instruction word
//   o_pipe_PC           registered PC of the instruction sent to decode
//   o_pipe_Instruction  registered instruction (NOP for a bubble)
//   o_pipe_Valid        registered valid (0 = bubble)
//
// Configuration macro:
//   LIGHT_FETCH_JAL_PREDECODE_EN  when defined, an accepted JAL response
//                                 retargets the next fetch to PC + J-imm.
// -----------------------------------------------------------------------------
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_pipe_stall,
    input  logic        i_Redirect,
    input  logic [31:0] i_RedirectPC,
    output logic        o_ImemReq,
    output logic [31:0] o_ImemAddr,
    input  logic        i_ImemGnt,
    input  logic        i_ImemRvalid,
    input  logic [31:0] i_ImemRdata,
    output logic [31:0] o_pipe_PC,
    output logic [31:0] o_pipe_Instruction,
    output logic        o_pipe_Valid
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  hold_pc;
    logic [31:0]  hold_instr;
    logic [31:0]  resp_pc;
    logic [31:0]  resp_next_pc;

    // The PC is bumped at grant time, so the outstanding request's address
    // is always one word behind it while a response is pending.
    assign resp_pc = pc - 32'd4;

`ifdef LIGHT_FETCH_JAL_PREDECODE_EN
    assign resp_next_pc = (i_ImemRdata[6:0] == OPCODE_JAL)
                          ? resp_pc + j_imm(i_ImemRdata) : pc;
`else
    assign resp_next_pc = pc;
`endif

    // A redirect cycle never issues a request: the PC is about to change.
    assign o_ImemReq  = (state == ST_IDLE) && !i_Redirect;
    assign o_ImemAddr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= ST_IDLE;
            pc                 <= RESET_PC;
            hold_pc            <= 32'd0;
            hold_instr         <= 32'd0;
            o_pipe_PC          <= 32'd0;
            o_pipe_Instruction <= NOP_INSTR;
            o_pipe_Valid       <= 1'b0;
        end else if (i_Redirect) begin
            pc                 <= {i_RedirectPC[31:2], 2'b00};
            o_pipe_Instruction <= NOP_INSTR;
            o_pipe_Valid       <= 1'b0;
            hold_pc            <= 32'd0;
            hold_instr         <= 32'd0;
            case (state)
                ST_IDLE: state <= i_ImemGnt ? ST_DROP : ST_IDLE;
                ST_WAIT: state <= i_ImemRvalid ? ST_IDLE : ST_DROP;
                ST_HOLD: state <= ST_IDLE;
                // A response consumed in this same cycle already satisfies
                // the drop; otherwise keep waiting for the stale one.
                ST_DROP: state <= i_ImemRvalid ? ST_IDLE : ST_DROP;
            endcase
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_ImemGnt) begin
                        pc    <= pc + 32'd4;
                        state <= ST_WAIT;
                    end
                    if (!i_pipe_stall) begin
                        o_pipe_Instruction <= NOP_INSTR;
                        o_pipe_Valid       <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (i_ImemRvalid) begin
                        pc <= resp_next_pc;
                        if (!i_pipe_stall) begin
                            o_pipe_PC          <= resp_pc;
                            o_pipe_Instruction <= i_ImemRdata;
                            o_pipe_Valid       <= 1'b1;
                            state              <= ST_IDLE;
                        end else begin
                            hold_pc    <= resp_pc;
                            hold_instr <= i_ImemRdata;
                            state      <= ST_HOLD;
                        end
                    end else if (!i_pipe_stall) begin
                        o_pipe_Instruction <= NOP_INSTR;
                        o_pipe_Valid       <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!i_pipe_stall) begin
                        o_pipe_PC          <= hold_pc;
                        o_pipe_Instruction <= hold_instr;
                        o_pipe_Valid       <= 1'b1;
                        state              <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (i_ImemRvalid) begin
                        state <= ST_IDLE;
                    end
                    if (!i_pipe_stall) begin
                        o_pipe_Instruction <= NOP_INSTR;
                        o_pipe_Valid       <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
